// File: rtl/cardinal_pkg.sv
// Shared definitions for the Cardinal fetch/decode front end.
//   - opcode constants (instruction bits [0:5], bit 0 = MSB)
//   - issue class encodings
//   - instruction field positions, expressed on a [31:0] vector
//   - decoded-instruction bundle and the opcode decoder
//   - scoreboard counter width helper
package cardinal_pkg;

  localparam logic [5:0] OP_R_ALU = 6'b101010;
  localparam logic [5:0] OP_LOAD  = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_BEZ   = 6'b100010;
  localparam logic [5:0] OP_BNEZ  = 6'b100011;
  localparam logic [5:0] OP_NOP   = 6'b111100;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } iss_class_e;

  // Instruction bit k (MSB-first numbering) lives at vector bit 31-k.
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 21;
  localparam int RA_HI   = 20;
  localparam int RA_LO   = 16;
  localparam int RB_HI   = 15;
  localparam int RB_LO   = 11;
  localparam int PPP_HI  = 10;
  localparam int PPP_LO  = 8;
  localparam int WW_HI   = 7;
  localparam int WW_LO   = 6;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  typedef struct packed {
    iss_class_e cls;
    logic       wr;        // writes the register file
    logic       rd_src_a;  // port A reads rD instead of rA
    logic       use_a;
    logic       use_b;
    logic       is_alu;
    logic       is_load;
    logic       is_bez;
    logic       is_bnez;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_R_ALU: begin
        d.cls    = CLS_ALU;
        d.wr     = 1'b1;
        d.use_a  = 1'b1;
        d.use_b  = 1'b1;
        d.is_alu = 1'b1;
      end
      OP_LOAD: begin
        d.cls     = CLS_LOAD;
        d.wr      = 1'b1;
        d.is_load = 1'b1;
      end
      OP_STORE: begin
        d.cls      = CLS_STORE;
        d.use_a    = 1'b1;
        d.rd_src_a = 1'b1;
      end
      OP_BEZ: begin
        d.cls      = CLS_BRANCH;
        d.use_a    = 1'b1;
        d.rd_src_a = 1'b1;
        d.is_bez   = 1'b1;
      end
      OP_BNEZ: begin
        d.cls      = CLS_BRANCH;
        d.use_a    = 1'b1;
        d.rd_src_a = 1'b1;
        d.is_bnez  = 1'b1;
      end
      default: ;  // OP_NOP and every unknown opcode
    endcase
    return d;
  endfunction

  // Counter must hold the larger latency; never narrower than one bit.
  function automatic int cw_of(input int ld_lat, input int alu_lat);
    int m;
    m = (ld_lat > alu_lat) ? ld_lat : alu_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cardinal_scoreboard.sv
// Per-register pending-write tracker.
//   Clock, reset          clock / synchronous active-high reset
//   hold                  freeze all state (EX back-pressure)
//   iss_en, iss_ld, iss_rd   a writer issues this cycle; iss_ld selects load latency
//   src_a/src_b, *_en     source registers queried by the instruction in ID
//   fwd_ok                consumer may take ALU results from the forwarding path
//   busy                  at least one enabled source is still pending
module cardinal_scoreboard #(
  parameter int NREG    = 32,
  parameter int CW      = 2,
  parameter int LD_LAT  = 2,
  parameter int ALU_LAT = 1
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       iss_en,
  input  logic       iss_ld,
  input  logic [4:0] iss_rd,
  input  logic [4:0] src_a,
  input  logic       src_a_en,
  input  logic [4:0] src_b,
  input  logic       src_b_en,
  input  logic       fwd_ok,
  output logic       busy
);

  logic [CW-1:0] pend_cnt_q [NREG];
  logic [CW-1:0] pend_cnt_d [NREG];
  logic          pend_ld_q  [NREG];
  logic          pend_ld_d  [NREG];

  logic a_busy, b_busy;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_cnt_d[r] = pend_cnt_q[r];
      pend_ld_d[r]  = pend_ld_q[r];
    end
    if (!hold) begin
      for (int r = 0; r < NREG; r++) begin
        if (pend_cnt_q[r] != '0) pend_cnt_d[r] = pend_cnt_q[r] - 1'b1;
      end
      // A fresh issue overrides the decrement on the same register.
      if (iss_en) begin
        pend_cnt_d[iss_rd] = iss_ld ? CW'(LD_LAT) : CW'(ALU_LAT);
        pend_ld_d[iss_rd]  = iss_ld;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        pend_cnt_q[r] <= '0;
        pend_ld_q[r]  <= 1'b0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_cnt_q[r] <= pend_cnt_d[r];
        pend_ld_q[r]  <= pend_ld_d[r];
      end
    end
  end

  // ALU-produced values are forwardable to ALU consumers; load results are not.
  always_comb begin
    a_busy = src_a_en && (pend_cnt_q[src_a] != '0) && !(fwd_ok && !pend_ld_q[src_a]);
    b_busy = src_b_en && (pend_cnt_q[src_b] != '0) && !(fwd_ok && !pend_ld_q[src_b]);
    busy   = a_busy || b_busy;
  end

endmodule

// File: rtl/cardinal_pipe_frontend.sv
// Cardinal vector core fetch/decode front end.
// Holds the PC and IF/ID register, decodes the instruction in ID, resolves
// BEZ/BNEZ in ID, stalls on scoreboard hazards and registers the ID/EX bundle.
//   Clock, reset          clock / synchronous active-high reset
//   Instruction, Instr_Addr   instruction memory interface (same-cycle data)
//   rf_ra_addr, rf_rb_addr, rf_ra_data   register file read ports
//   ex_busy               multi-cycle EX operation freezes the whole front end
//   iss_*                 registered ID/EX issue bundle
//   stall, flush          combinational ID status
module cardinal_pipe_frontend
  import cardinal_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int NREG    = 32,
  parameter int DATA_W  = 64,
  parameter int LD_LAT  = 2,
  parameter int ALU_LAT = 1,
  parameter int FWD_EN  = 1
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] Instr_Addr,
  output logic [4:0]        rf_ra_addr,
  output logic [4:0]        rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic              ex_busy,
  output logic              iss_valid,
  output logic [2:0]        iss_class,
  output logic [4:0]        iss_rd,
  output logic [2:0]        iss_ppp,
  output logic [1:0]        iss_ww,
  output logic [5:0]        iss_func,
  output logic [ADDR_W-1:0] iss_imm,
  output logic              iss_wr,
  output logic              stall,
  output logic              flush
);

  localparam int CW = cw_of(LD_LAT, ALU_LAT);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              id_valid_q, id_valid_d;

  logic              iss_valid_q, iss_valid_d;
  logic [2:0]        iss_class_q, iss_class_d;
  logic [4:0]        iss_rd_q, iss_rd_d;
  logic [2:0]        iss_ppp_q, iss_ppp_d;
  logic [1:0]        iss_ww_q, iss_ww_d;
  logic [5:0]        iss_func_q, iss_func_d;
  logic [ADDR_W-1:0] iss_imm_q, iss_imm_d;
  logic              iss_wr_q, iss_wr_d;

  dec_t              dec;
  logic [4:0]        fld_rd, fld_ra, fld_rb;
  logic [ADDR_W-1:0] target;
  logic              taken, sb_busy, issue_wr, advance;

  always_comb begin
    dec    = decode_op(ir_q[OP_HI:OP_LO]);
    fld_rd = ir_q[RD_HI:RD_LO];
    fld_ra = ir_q[RA_HI:RA_LO];
    fld_rb = ir_q[RB_HI:RB_LO];
    target = ir_q[ADDR_W-1:0];
  end

  assign rf_ra_addr = dec.rd_src_a ? fld_rd : fld_ra;
  assign rf_rb_addr = fld_rb;

  cardinal_scoreboard #(
    .NREG    (NREG),
    .CW      (CW),
    .LD_LAT  (LD_LAT),
    .ALU_LAT (ALU_LAT)
  ) u_scoreboard (
    .Clock    (Clock),
    .reset    (reset),
    .hold     (ex_busy),
    .iss_en   (issue_wr),
    .iss_ld   (dec.is_load),
    .iss_rd   (fld_rd),
    .src_a    (rf_ra_addr),
    .src_a_en (id_valid_q && dec.use_a),
    .src_b    (fld_rb),
    .src_b_en (id_valid_q && dec.use_b),
    .fwd_ok   ((FWD_EN != 0) && dec.is_alu),
    .busy     (sb_busy)
  );

  always_comb begin
    taken    = (dec.is_bez  && (rf_ra_data == '0)) ||
               (dec.is_bnez && (rf_ra_data != '0));
    stall    = id_valid_q && !ex_busy && sb_busy;
    // advance: the ID instruction (or empty slot) moves into ID/EX this edge
    advance  = !ex_busy && !stall;
    flush    = id_valid_q && advance && taken;
    issue_wr = id_valid_q && advance && dec.wr;
  end

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    id_valid_d  = id_valid_q;
    iss_valid_d = iss_valid_q;
    iss_class_d = iss_class_q;
    iss_rd_d    = iss_rd_q;
    iss_ppp_d   = iss_ppp_q;
    iss_ww_d    = iss_ww_q;
    iss_func_d  = iss_func_q;
    iss_imm_d   = iss_imm_q;
    iss_wr_d    = iss_wr_q;
    if (!ex_busy) begin
      if (stall) begin
        // PC and IF/ID hold; EX receives a bubble.
        iss_valid_d = 1'b0;
        iss_class_d = CLS_NOP;
        iss_rd_d    = '0;
        iss_ppp_d   = '0;
        iss_ww_d    = '0;
        iss_func_d  = '0;
        iss_imm_d   = '0;
        iss_wr_d    = 1'b0;
      end else begin
        iss_valid_d = id_valid_q;
        iss_class_d = id_valid_q ? dec.cls : CLS_NOP;
        iss_rd_d    = id_valid_q ? fld_rd : '0;
        iss_ppp_d   = id_valid_q ? ir_q[PPP_HI:PPP_LO] : '0;
        iss_ww_d    = id_valid_q ? ir_q[WW_HI:WW_LO] : '0;
        iss_func_d  = id_valid_q ? ir_q[FUNC_HI:FUNC_LO] : '0;
        iss_imm_d   = id_valid_q ? target : '0;
        iss_wr_d    = id_valid_q && dec.wr;
        ir_d        = Instruction;
        if (flush) begin
          // The word fetched this cycle is the fall-through path: drop it.
          pc_d       = target;
          id_valid_d = 1'b0;
        end else begin
          pc_d       = pc_q + 1'b1;
          id_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      pc_q        <= '0;
      ir_q        <= '0;
      id_valid_q  <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_class_q <= '0;
      iss_rd_q    <= '0;
      iss_ppp_q   <= '0;
      iss_ww_q    <= '0;
      iss_func_q  <= '0;
      iss_imm_q   <= '0;
      iss_wr_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      id_valid_q  <= id_valid_d;
      iss_valid_q <= iss_valid_d;
      iss_class_q <= iss_class_d;
      iss_rd_q    <= iss_rd_d;
      iss_ppp_q   <= iss_ppp_d;
      iss_ww_q    <= iss_ww_d;
      iss_func_q  <= iss_func_d;
      iss_imm_q   <= iss_imm_d;
      iss_wr_q    <= iss_wr_d;
    end
  end

  assign Instr_Addr = pc_q;
  assign iss_valid  = iss_valid_q;
  assign iss_class  = iss_class_q;
  assign iss_rd     = iss_rd_q;
  assign iss_ppp    = iss_ppp_q;
  assign iss_ww     = iss_ww_q;
  assign iss_func   = iss_func_q;
  assign iss_imm    = iss_imm_q;
  assign iss_wr     = iss_wr_q;

endmodule

// File: tb/tb_cardinal_pipe_frontend.sv
// Directed bench for cardinal_pipe_frontend with default parameters
// (ADDR_W=8, LD_LAT=2, ALU_LAT=1, FWD_EN=1). Instruction memory and the
// register file read port A are modelled here; expected values are hand-derived.
module tb_cardinal_pipe_frontend;

  logic        Clock;
  logic        reset;
  logic [31:0] Instruction;
  logic [7:0]  Instr_Addr;
  logic [4:0]  rf_ra_addr, rf_rb_addr;
  logic [63:0] rf_ra_data;
  logic        ex_busy;
  logic        iss_valid;
  logic [2:0]  iss_class;
  logic [4:0]  iss_rd;
  logic [2:0]  iss_ppp;
  logic [1:0]  iss_ww;
  logic [5:0]  iss_func;
  logic [7:0]  iss_imm;
  logic        iss_wr;
  logic        stall, flush;

  logic [31:0] imem [256];
  logic [63:0] rf   [32];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP_W = 32'hF000_0000;

  cardinal_pipe_frontend u_dut (
    .Clock       (Clock),
    .reset       (reset),
    .Instruction (Instruction),
    .Instr_Addr  (Instr_Addr),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .ex_busy     (ex_busy),
    .iss_valid   (iss_valid),
    .iss_class   (iss_class),
    .iss_rd      (iss_rd),
    .iss_ppp     (iss_ppp),
    .iss_ww      (iss_ww),
    .iss_func    (iss_func),
    .iss_imm     (iss_imm),
    .iss_wr      (iss_wr),
    .stall       (stall),
    .flush       (flush)
  );

  assign Instruction = imem[Instr_Addr];
  assign rf_ra_data  = rf[rf_ra_addr];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] enc_alu(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    return {6'b101010, rd, ra, rb, 3'd5, 2'd2, 6'h2A};
  endfunction

  function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [7:0] addr);
    return {6'b100000, rd, 13'd0, addr};
  endfunction

  function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [4:0] rd, input logic [7:0] tgt);
    return {op, rd, 13'd0, tgt};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = NOP_W;
  endtask

  // Leaves reset released at #1 after an edge; the next edge is edge 1.
  task automatic do_reset();
    reset   = 1'b1;
    ex_busy = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    ex_busy = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 64'h1;
    rf[5] = 64'h0;
    rf[2] = 64'h0;

    // 1: independent ALU stream, field capture, unknown opcode
    clear_imem();
    imem[0] = enc_alu(5'd1, 5'd10, 5'd11);
    imem[1] = enc_alu(5'd2, 5'd12, 5'd13);
    imem[2] = enc_alu(5'd3, 5'd14, 5'd15);
    imem[3] = {6'b000111, 5'd9, 21'd0};
    do_reset();
    check_eq("rst_pc", Instr_Addr, 8'h00);
    check_eq("rst_valid", iss_valid, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_flush", flush, 1'b0);
    step();
    check_eq("t1_pc1", Instr_Addr, 8'h01);
    check_eq("t1_valid1", iss_valid, 1'b0);
    step();
    check_eq("t1_pc2", Instr_Addr, 8'h02);
    check_eq("t1_valid2", iss_valid, 1'b1);
    check_eq("t1_class", iss_class, 3'd1);
    check_eq("t1_rd1", iss_rd, 5'd1);
    check_eq("t1_wr", iss_wr, 1'b1);
    check_eq("t1_ppp", iss_ppp, 3'd5);
    check_eq("t1_ww", iss_ww, 2'd2);
    check_eq("t1_func", iss_func, 6'h2A);
    step();
    check_eq("t1_pc3", Instr_Addr, 8'h03);
    check_eq("t1_rd2", iss_rd, 5'd2);
    check_eq("t1_stall", stall, 1'b0);
    step();
    check_eq("t1_rd3", iss_rd, 5'd3);
    step();
    check_eq("t1_unk_class", iss_class, 3'd0);
    check_eq("t1_unk_wr", iss_wr, 1'b0);

    // 2a: load-use, two bubbles
    clear_imem();
    imem[0] = enc_ld(5'd3, 8'h10);
    imem[1] = enc_alu(5'd4, 5'd3, 5'd1);
    do_reset();
    step();
    check_eq("t2_ld_nostall", stall, 1'b0);
    step();
    check_eq("t2_ld_class", iss_class, 3'd2);
    check_eq("t2_ld_imm", iss_imm, 8'h10);
    check_eq("t2_ld_rd", iss_rd, 5'd3);
    check_eq("t2_stall_a", stall, 1'b1);
    step();
    check_eq("t2_bubble1", iss_valid, 1'b0);
    check_eq("t2_pc_hold", Instr_Addr, 8'h02);
    check_eq("t2_stall_b", stall, 1'b1);
    step();
    check_eq("t2_bubble2", iss_valid, 1'b0);
    check_eq("t2_stall_c", stall, 1'b0);
    step();
    check_eq("t2_use_valid", iss_valid, 1'b1);
    check_eq("t2_use_rd", iss_rd, 5'd4);
    check_eq("t2_pc_go", Instr_Addr, 8'h03);

    // 2b: ALU-to-ALU with forwarding, no bubble
    clear_imem();
    imem[0] = enc_alu(5'd3, 5'd1, 5'd2);
    imem[1] = enc_alu(5'd4, 5'd3, 5'd3);
    do_reset();
    step();
    step();
    check_eq("t2f_stall", stall, 1'b0);
    step();
    check_eq("t2f_valid", iss_valid, 1'b1);
    check_eq("t2f_rd", iss_rd, 5'd4);
    check_eq("t2f_pc", Instr_Addr, 8'h03);

    // 3: taken BEZ, fall-through killed
    clear_imem();
    imem[0]     = enc_br(6'b100010, 5'd5, 8'h40);
    imem[1]     = enc_alu(5'd7, 5'd1, 5'd1);
    imem[8'h40] = enc_alu(5'd8, 5'd1, 5'd2);
    do_reset();
    step();
    check_eq("t3_ra_addr", rf_ra_addr, 5'd5);
    check_eq("t3_flush", flush, 1'b1);
    step();
    check_eq("t3_pc_tgt", Instr_Addr, 8'h40);
    check_eq("t3_br_class", iss_class, 3'd4);
    check_eq("t3_br_wr", iss_wr, 1'b0);
    check_eq("t3_br_imm", iss_imm, 8'h40);
    check_eq("t3_flush_off", flush, 1'b0);
    step();
    check_eq("t3_bubble", iss_valid, 1'b0);
    step();
    check_eq("t3_tgt_rd", iss_rd, 5'd8);
    check_eq("t3_tgt_valid", iss_valid, 1'b1);

    // 4a: BNEZ on zero, not taken
    clear_imem();
    imem[0] = enc_br(6'b100011, 5'd5, 8'h40);
    imem[1] = enc_alu(5'd9, 5'd1, 5'd2);
    do_reset();
    step();
    check_eq("t4a_flush", flush, 1'b0);
    check_eq("t4a_stall", stall, 1'b0);
    step();
    check_eq("t4a_pc", Instr_Addr, 8'h02);
    check_eq("t4a_class", iss_class, 3'd4);
    step();
    check_eq("t4a_next_rd", iss_rd, 5'd9);
    check_eq("t4a_next_valid", iss_valid, 1'b1);

    // 4b: BEZ waits for ALU producer (no forwarding to branches)
    clear_imem();
    imem[0]     = enc_alu(5'd2, 5'd1, 5'd1);
    imem[1]     = enc_br(6'b100010, 5'd2, 8'h20);
    imem[8'h20] = enc_alu(5'd10, 5'd1, 5'd1);
    do_reset();
    step();
    step();
    check_eq("t4b_stall", stall, 1'b1);
    check_eq("t4b_noflush", flush, 1'b0);
    step();
    check_eq("t4b_pc_hold", Instr_Addr, 8'h02);
    check_eq("t4b_stall_off", stall, 1'b0);
    check_eq("t4b_flush", flush, 1'b1);
    step();
    check_eq("t4b_pc_tgt", Instr_Addr, 8'h20);
    check_eq("t4b_br_class", iss_class, 3'd4);
    step();
    check_eq("t4b_bubble", iss_valid, 1'b0);
    step();
    check_eq("t4b_tgt_rd", iss_rd, 5'd10);

    // 5: ex_busy freeze with a load pending
    clear_imem();
    imem[0] = enc_ld(5'd3, 8'h11);
    imem[1] = enc_alu(5'd5, 5'd1, 5'd1);
    imem[2] = enc_alu(5'd6, 5'd3, 5'd1);
    do_reset();
    step();
    step();
    ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_busy_stall", stall, 1'b0);
      step();
      check_eq("t5_busy_pc", Instr_Addr, 8'h02);
      check_eq("t5_busy_class", iss_class, 3'd2);
      check_eq("t5_busy_rd", iss_rd, 5'd3);
    end
    ex_busy = 1'b0;
    step();
    check_eq("t5_res_rd", iss_rd, 5'd5);
    check_eq("t5_res_pc", Instr_Addr, 8'h03);
    check_eq("t5_res_stall", stall, 1'b1);
    step();
    check_eq("t5_res_bubble", iss_valid, 1'b0);
    step();
    check_eq("t5_use_rd", iss_rd, 5'd6);
    check_eq("t5_use_valid", iss_valid, 1'b1);

    // 6: reset during load-use stall clears scoreboard
    clear_imem();
    imem[0] = enc_ld(5'd3, 8'h10);
    imem[1] = enc_alu(5'd4, 5'd3, 5'd1);
    do_reset();
    step();
    step();
    check_eq("t6_stall", stall, 1'b1);
    reset   = 1'b1;
    imem[0] = enc_alu(5'd4, 5'd3, 5'd3);
    step();
    check_eq("t6_rst_pc", Instr_Addr, 8'h00);
    check_eq("t6_rst_valid", iss_valid, 1'b0);
    check_eq("t6_rst_stall", stall, 1'b0);
    reset = 1'b0;
    step();
    check_eq("t6_sb_clear", stall, 1'b0);

    // 6b: PC wrap via branch to 0xFE
    clear_imem();
    imem[0] = enc_br(6'b100010, 5'd5, 8'hFE);
    do_reset();
    step();
    step();
    check_eq("t6_pc_fe", Instr_Addr, 8'hFE);
    step();
    check_eq("t6_pc_ff", Instr_Addr, 8'hFF);
    step();
    check_eq("t6_pc_wrap", Instr_Addr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
